// File: rtl/riscv_isa_pkg.sv
// Shared RV32I encoding definitions: type codes, opcodes, error codes and
// per-format packing functions. The decode core uses the same layout.
package riscv_isa_pkg;

  localparam logic [3:0] R_TYPE = 4'd1;
  localparam logic [3:0] I_TYPE = 4'd2;
  localparam logic [3:0] S_TYPE = 4'd3;
  localparam logic [3:0] B_TYPE = 4'd4;
  localparam logic [3:0] U_TYPE = 4'd5;
  localparam logic [3:0] J_TYPE = 4'd6;

  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_TYPE   = 3'd1,
    ERR_OPCODE = 3'd2,
    ERR_ALIGN  = 3'd3,
    ERR_RANGE  = 3'd4
  } err_code_e;

  function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] pack_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // imm carries bits [12:1]; bit 0 of a branch offset is always zero.
  function automatic logic [31:0] pack_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] pack_u(input logic [31:12] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] pack_j(input logic [20:1] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

endpackage

// File: rtl/riscv_encode_fifo.sv
// Synchronous DEPTH x WIDTH FIFO; when empty the output holds the last popped word.
module riscv_encode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic [WIDTH-1:0] r_last;
  logic             w_do_push;
  logic             w_do_pop;

  // DEPTH is a power of two, so the level MSB alone marks full.
  assign o_full    = r_level[PTR_W];
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/riscv_encode_core.sv
// RV32I instruction encoder: validates a decoded field bundle, packs legal ones
// into a 32-bit word and queues it; rejects are reported with an error code.
module riscv_encode_core
  import riscv_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_type,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     err_valid,
  output logic [2:0]               err_code,
  output logic [CNT_W-1:0]         enc_count,
  output logic [CNT_W-1:0]         rej_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_accept;
  logic               w_push;
  logic               w_op_ok;
  logic [31:0]        w_word;
  logic signed [31:0] w_simm;
  err_code_e          w_err;
  err_code_e          r_err_code;
  logic               r_err_valid;
  logic [CNT_W-1:0]   r_enc_count;
  logic [CNT_W-1:0]   r_rej_count;

  assign w_simm    = in_imm;
  assign in_ready  = ~w_fifo_full;
  assign w_accept  = in_valid & in_ready;
  assign w_push    = w_accept & (w_err == ERR_NONE);
  assign out_valid = ~w_fifo_empty;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign enc_count = r_enc_count;
  assign rej_count = r_rej_count;

  // Range is assigned before alignment and opcode so the higher-priority code wins.
  always_comb begin
    w_err   = ERR_NONE;
    w_word  = '0;
    w_op_ok = 1'b1;
    case (in_type)
      R_TYPE: begin
        w_op_ok = (in_opcode == OP_OP);
        w_word  = pack_r(in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode);
      end
      I_TYPE: begin
        w_op_ok = (in_opcode == OP_IMM) || (in_opcode == OP_LOAD) || (in_opcode == OP_JALR);
        w_word  = pack_i(in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode);
        if (w_simm < -32'sd2048 || w_simm > 32'sd2047) w_err = ERR_RANGE;
      end
      S_TYPE: begin
        w_op_ok = (in_opcode == OP_STORE);
        w_word  = pack_s(in_imm[11:0], in_rs2, in_rs1, in_funct3, in_opcode);
        if (w_simm < -32'sd2048 || w_simm > 32'sd2047) w_err = ERR_RANGE;
      end
      B_TYPE: begin
        w_op_ok = (in_opcode == OP_BRANCH);
        w_word  = pack_b(in_imm[12:1], in_rs2, in_rs1, in_funct3, in_opcode);
        if (w_simm < -32'sd4096 || w_simm > 32'sd4094) w_err = ERR_RANGE;
        if (in_imm[0]) w_err = ERR_ALIGN;
      end
      U_TYPE: begin
        w_op_ok = (in_opcode == OP_LUI) || (in_opcode == OP_AUIPC);
        w_word  = pack_u(in_imm[31:12], in_rd, in_opcode);
        if (in_imm[11:0] != 12'd0) w_err = ERR_ALIGN;
      end
      J_TYPE: begin
        w_op_ok = (in_opcode == OP_JAL);
        w_word  = pack_j(in_imm[20:1], in_rd, in_opcode);
        if (w_simm < -32'sd1048576 || w_simm > 32'sd1048574) w_err = ERR_RANGE;
        if (in_imm[0]) w_err = ERR_ALIGN;
      end
      default: w_err = ERR_TYPE;
    endcase
    if (!w_op_ok) w_err = ERR_OPCODE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_enc_count <= '0;
      r_rej_count <= '0;
    end else begin
      r_err_valid <= 1'b0;
      if (w_accept) begin
        r_err_code <= w_err;
        if (w_err != ERR_NONE) begin
          r_err_valid <= 1'b1;
          r_rej_count <= r_rej_count + 1'b1;
        end else begin
          r_enc_count <= r_enc_count + 1'b1;
        end
      end
    end
  end

  riscv_encode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (out_ready),
    .o_data  (out_instr),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

endmodule

// File: tb/tb_riscv_encode_core.sv
// Directed and random checks of riscv_encode_core against a queue-based
// reference model derived from the RV32I field placement rules.
module tb_riscv_encode_core;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_type;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             err_valid;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] enc_count, rej_count;
  logic [$clog2(DEPTH):0] fifo_level;

  int assertCount = 0;
  int failCount = 0;

  logic [31:0]      expQ[$];
  logic [31:0]      lastPopped;
  logic [CNT_W-1:0] mEnc, mRej;
  logic             mErrValid;
  logic [2:0]       mErrCode;

  riscv_encode_core #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_valid(err_valid), .err_code(err_code), .enc_count(enc_count),
    .rej_count(rej_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bitsOf(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Each format places shifted immediate slices around the register fields.
  function automatic logic [31:0] refEncode(input int t, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w;
    w = 32'(op);
    case (t)
      1: w = w + (32'(f7) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15) + (32'(f3) << 12) + (32'(rd) << 7);
      2: w = w + (bitsOf(imm, 11, 0) << 20) + (32'(rs1) << 15) + (32'(f3) << 12) + (32'(rd) << 7);
      3: w = w + (bitsOf(imm, 11, 5) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15) + (32'(f3) << 12)
             + (bitsOf(imm, 4, 0) << 7);
      4: w = w + (bitsOf(imm, 12, 12) << 31) + (bitsOf(imm, 10, 5) << 25) + (32'(rs2) << 20)
             + (32'(rs1) << 15) + (32'(f3) << 12) + (bitsOf(imm, 4, 1) << 8) + (bitsOf(imm, 11, 11) << 7);
      5: w = w + (bitsOf(imm, 31, 12) << 12) + (32'(rd) << 7);
      6: w = w + (bitsOf(imm, 20, 20) << 31) + (bitsOf(imm, 10, 1) << 21) + (bitsOf(imm, 11, 11) << 20)
             + (bitsOf(imm, 19, 12) << 12) + (32'(rd) << 7);
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic bit legalOp(input int t, input int op);
    case (t)
      1: return op == 'h33;
      2: return op == 'h13 || op == 'h03 || op == 'h67;
      3: return op == 'h23;
      4: return op == 'h63;
      5: return op == 'h37 || op == 'h17;
      6: return op == 'h6F;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int refCheck(input int t, input int op, input logic [31:0] imm);
    int s;
    s = imm;
    if (t < 1 || t > 6) return 1;
    if (!legalOp(t, op)) return 2;
    if ((t == 4 || t == 6) && imm[0]) return 3;
    if (t == 5 && imm[11:0] != 12'd0) return 3;
    if ((t == 2 || t == 3) && (s < -2048 || s > 2047)) return 4;
    if (t == 4 && (s < -4096 || s > 4094)) return 4;
    if (t == 6 && (s < -1048576 || s > 1048574)) return 4;
    return 0;
  endfunction

  function automatic logic [6:0] pickOpcode(input int t);
    case (t)
      1: return 7'h33;
      2: begin
        case ($urandom_range(0, 2))
          0: return 7'h13;
          1: return 7'h03;
          default: return 7'h67;
        endcase
      end
      3: return 7'h23;
      4: return 7'h63;
      5: return ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
      6: return 7'h6F;
      default: return 7'($urandom);
    endcase
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then advance the model by what that edge must have done.
  task automatic applyStimulus(input logic v, input logic [3:0] t, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm, input logic ordy);
    int e;
    bit acc, popNow;
    in_valid = v; in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; out_ready = ordy;
    acc = v && (expQ.size() < DEPTH);
    popNow = ordy && (expQ.size() > 0);
    @(posedge clk);
    if (popNow) lastPopped = expQ.pop_front();
    mErrValid = 1'b0;
    if (acc) begin
      e = refCheck(int'(t), int'(op), imm);
      mErrCode = 3'(e);
      if (e == 0) begin
        expQ.push_back(refEncode(int'(t), op, rd, rs1, rs2, f3, f7, imm));
        mEnc++;
      end else begin
        mErrValid = 1'b1;
        mRej++;
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, ordy);
  endtask

  task automatic doReset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
    lastPopped = '0; mEnc = '0; mRej = '0; mErrValid = 1'b0; mErrCode = '0;
  endtask

  task automatic checkOutput(input string tag);
    expectEq({tag, ".in_ready"}, 32'(in_ready), 32'(expQ.size() < DEPTH));
    expectEq({tag, ".out_valid"}, 32'(out_valid), 32'(expQ.size() > 0));
    expectEq({tag, ".out_instr"}, out_instr, (expQ.size() > 0) ? expQ[0] : lastPopped);
    expectEq({tag, ".err_valid"}, 32'(err_valid), 32'(mErrValid));
    expectEq({tag, ".err_code"}, 32'(err_code), 32'(mErrCode));
    expectEq({tag, ".enc_count"}, 32'(enc_count), 32'(mEnc));
    expectEq({tag, ".rej_count"}, 32'(rej_count), 32'(mRej));
    expectEq({tag, ".fifo_level"}, 32'(fifo_level), 32'(expQ.size()));
  endtask

  initial begin
    logic [31:0] r, imm;
    int t;
    reset = 1'b1;
    in_valid = 1'b0; in_type = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; out_ready = 1'b0;
    @(posedge clk);
    doReset();
    checkOutput("reset");
    expectEq("reset.out_instr_zero", out_instr, 32'h0);

    applyStimulus(1, 4'd2, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 1);
    checkOutput("addi");
    expectEq("addi.word", out_instr, 32'h00510093);
    expectEq("addi.enc", 32'(enc_count), 32'd1);
    applyStimulus(1, 4'd1, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1);
    checkOutput("add");
    expectEq("add.word", out_instr, 32'h002081B3);
    applyStimulus(1, 4'd3, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 1);
    checkOutput("sw");
    expectEq("sw.word", out_instr, 32'h00512423);
    applyStimulus(1, 4'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1);
    checkOutput("beq");
    expectEq("beq.word", out_instr, 32'hFE000EE3);
    applyStimulus(1, 4'd5, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1);
    checkOutput("lui");
    expectEq("lui.word", out_instr, 32'h123450B7);

    applyStimulus(1, 4'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1);
    checkOutput("bMisalign");
    expectEq("bMisalign.err_valid", 32'(err_valid), 32'd1);
    expectEq("bMisalign.err_code", 32'(err_code), 32'd3);
    expectEq("bMisalign.rej", 32'(rej_count), 32'd1);
    expectEq("bMisalign.enc", 32'(enc_count), 32'd5);
    idle(1, 1);
    checkOutput("errHold");
    expectEq("errHold.err_valid", 32'(err_valid), 32'd0);
    expectEq("errHold.err_code", 32'(err_code), 32'd3);
    applyStimulus(1, 4'd2, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048, 1);
    checkOutput("iRange");
    expectEq("iRange.err_code", 32'(err_code), 32'd4);
    applyStimulus(1, 4'd7, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 1);
    checkOutput("badType");
    expectEq("badType.err_code", 32'(err_code), 32'd1);
    applyStimulus(1, 4'd4, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1);
    checkOutput("opBeatsAlign");
    expectEq("opBeatsAlign.err_code", 32'(err_code), 32'd2);
    applyStimulus(1, 4'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576, 1);
    checkOutput("jRange");
    expectEq("jRange.err_code", 32'(err_code), 32'd4);
    applyStimulus(1, 4'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574, 1);
    checkOutput("jMax");
    expectEq("jMax.err_code", 32'(err_code), 32'd0);
    applyStimulus(1, 4'd5, 7'h17, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 1);
    checkOutput("uAlign");
    expectEq("uAlign.err_code", 32'(err_code), 32'd3);
    applyStimulus(1, 4'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000, 1);
    checkOutput("bMin");
    expectEq("bMin.err_code", 32'(err_code), 32'd0);
    idle(1, 2);
    checkOutput("drain");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'd2, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 7), 0);
      checkOutput("fill");
    end
    expectEq("full.level", 32'(fifo_level), 32'd4);
    expectEq("full.in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1, 4'd2, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd28, 1);
    checkOutput("fullPop");
    expectEq("fullPop.level", 32'(fifo_level), 32'd3);
    applyStimulus(1, 4'd2, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd28, 1);
    checkOutput("fifthIn");
    expectEq("fifthIn.level", 32'(fifo_level), 32'd3);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1);
      checkOutput("fifoOrder");
    end

    idle(0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 4'd1, 7'h33, 5'(i), 5'd3, 5'd4, 3'd1, 7'h20, 32'd0, 0);
      checkOutput("toLevel2");
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 4'd3, 7'h23, 5'd0, 5'(i), 5'(i + 9), 3'd2, 7'd0, 32'(-i * 4), 1);
      checkOutput("steady");
      expectEq("steady.level", 32'(fifo_level), 32'd2);
    end
    applyStimulus(1, 4'd5, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 0);
    checkOutput("toLevel3");
    expectEq("toLevel3.level", 32'(fifo_level), 32'd3);
    doReset();
    checkOutput("midReset");
    expectEq("midReset.level", 32'(fifo_level), 32'd0);
    expectEq("midReset.out_valid", 32'(out_valid), 32'd0);
    expectEq("midReset.enc", 32'(enc_count), 32'd0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      case ($urandom_range(0, 4))
        0: imm = {{20{r[11]}}, r[11:0]};
        1: imm = {{19{r[12]}}, r[12:1], 1'b0};
        2: imm = {r[31:12], 12'h0};
        3: imm = {{11{r[20]}}, r[20:1], r[0] & r[5]};
        default: imm = r;
      endcase
      t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 6));
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'(t),
                    ($urandom_range(0, 7) == 0) ? 7'($urandom) : pickOpcode(t),
                    5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                    imm, 1'($urandom_range(0, 4) < 3));
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
